key_expansion_unit: RTL and testbench
=====================================

# key_expansion_unit

AES-128 key schedule engine for the SIMD encryption datapath. On a start pulse it captures a 128-bit cipher key and produces round keys 0 through 10, one per cycle. Each round key is presented with a write-enable and index, so the downstream round-key register bank's `en`/`D` inputs load directly from this block. Byte substitution uses an external combinational S-box bank, shared with the datapath, through a 32-bit request/response port pair.

## Interface
Parameters:
- `NR`, default 10: number of rounds; round keys 0..NR are produced; only 10 is supported.

Ports:
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low (asserted at 0).
- `start`  in  1: begin expansion; sampled only in IDLE.
- `key_in`  in  128: cipher key, bit 127 = byte 0; sampled on the accepted start edge.
- `sbox_in`  out  32: RotWord(w3) of the current round key, driven to the external S-box.
- `sbox_out`  in  32: S-box result for `sbox_in`, combinational, same cycle.
- `rk_we`  out  1: round-key write enable, wired to the register bank `en`.
- `rk_idx`  out  4: index 0..10 of the round key on `rk_data`.
- `rk_data`  out  128: current round key, wired to the register bank `D`.
- `busy`  out  1: high whenever state is not IDLE.
- `done`  out  1: one-cycle pulse after round key 10 is written.

## Operation
- State register `key_q[127:0]` holds words w0..w3 (w0 = bits 127:96). `rk_data = key_q` at all times.
- FSM states: IDLE, LOAD, EXPAND, FIN.
  - IDLE -> LOAD on `start`=1. `key_q <= key_in`, `rk_idx <= 0`.
  - LOAD: `rk_we`=1, `rk_idx`=0. Always -> EXPAND.
  - EXPAND: each cycle compute the next round key and set `rk_idx <= rk_idx+1`. `rk_we`=1 on the cycle the new key is visible. When `rk_idx` reaches 10 -> FIN.
  - FIN: `done`=1, `rk_we`=0. Always -> IDLE.
- Next-key arithmetic, all XOR, no carries:
  - `t = sbox_out ^ {rcon[rk_idx+1], 24'h0}`
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36. The rcon table is an internal case constant.
- `sbox_in = {w3[23:0], w3[31:24]}`. It is driven continuously from `key_q`, in every state.
- `start` outside IDLE is ignored. There is no abort input; a new key requires completing the sequence or applying reset.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `key_q`=0, `rk_idx`=0. Outputs `rk_we`=0, `busy`=0, `done`=0, `rk_data`=0.
- Start accepted on edge E0:
  - `rk_we`=1 from the cycle after E0 for exactly 11 consecutive cycles, with `rk_idx` = 0,1,…,10.
  - `done` is high in the 12th cycle.
  - IDLE is re-entered in the 13th cycle.
- `busy` is high for 12 cycles: LOAD, EXPAND×10, FIN.
- Back-to-back: `start` held high in the first IDLE cycle after FIN is accepted. The minimum start-to-start spacing is 13 cycles.
- Reset mid-operation: all outputs go to reset values immediately, including any in-flight `rk_we`. After `rst` releases, the block waits in IDLE for a new start.
- `rk_data`, `rk_idx` and `rk_we` change only on clock edges, so the downstream register captures a stable value one edge later.

## Configuration
- `KEY_EXPANSION_ZEROIZE_EN` defined: on the FIN->IDLE transition `key_q` clears to 0, so `rk_data`=0 in IDLE after each expansion and no key material is retained.
- Macro not defined: `key_q` retains round key 10 in IDLE until the next start or reset.

## Test plan
- FIPS-197 vector: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `start` pulse, bench S-box model -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; `done` in the 12th cycle.
- Handshake counts: any key -> exactly 11 `rk_we` cycles with contiguous `rk_idx` 0..10, 12 `busy` cycles, one `done` pulse.
- `start` re-asserted at idx 5 -> ignored; the sequence and `rk_data` match an uninterrupted run.
- `rst`=0 asynchronously at idx 4 -> `rk_we`, `busy`, `rk_data` go to 0 without a clock edge. A new start after release produces a full correct sequence.
- Zero key 000…0 -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Post-done IDLE: with `KEY_EXPANSION_ZEROIZE_EN` -> `rk_data`=0; without -> `rk_data` holds the idx10 value. Both builds are run.

Source files
------------

// File: rtl/key_expansion_unit_if.sv
// Bus bundle between the AES-128 key schedule engine, its round-key consumer
// and the shared external S-box bank.
interface key_expansion_unit_if;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic         rk_we;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic         busy;
    logic         done;

    modport slave (
        input  start, key_in, sbox_out,
        output sbox_in, rk_we, rk_idx, rk_data, busy, done
    );

    modport master (
        output start, key_in, sbox_out,
        input  sbox_in, rk_we, rk_idx, rk_data, busy, done
    );
endinterface

// File: rtl/key_expansion_unit.sv
// AES-128 key schedule engine: emits round keys 0..10, one per cycle.
// Define KEY_EXPANSION_ZEROIZE_EN to clear the key register when returning to IDLE.
module key_expansion_unit #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    key_expansion_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, FIN} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t       state, state_next;
    logic [127:0] key_q, key_next;
    logic [3:0]   idx_q, idx_next;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t, n0, n1, n2, n3;
    logic [7:0]   rcon;
    logic         rk_we, busy, done;

    function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
        case (round)
            4'd1:    rcon_lookup = 8'h01;
            4'd2:    rcon_lookup = 8'h02;
            4'd3:    rcon_lookup = 8'h04;
            4'd4:    rcon_lookup = 8'h08;
            4'd5:    rcon_lookup = 8'h10;
            4'd6:    rcon_lookup = 8'h20;
            4'd7:    rcon_lookup = 8'h40;
            4'd8:    rcon_lookup = 8'h80;
            4'd9:    rcon_lookup = 8'h1b;
            4'd10:   rcon_lookup = 8'h36;
            default: rcon_lookup = 8'h00;
        endcase
    endfunction

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // The S-box sees RotWord(w3) of whatever key is held, in every state.
    assign bus.sbox_in = {w3[23:0], w3[31:24]};

    assign rcon = rcon_lookup(idx_q + 4'd1);
    assign t    = bus.sbox_out ^ {rcon, 24'h0};
    assign n0   = w0 ^ t;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            key_q <= '0;
            idx_q <= '0;
        end else begin
            state <= state_next;
            key_q <= key_next;
            idx_q <= idx_next;
        end
    end

    // LOAD already advances to round 1 so that a new key is visible every cycle.
    always_comb begin
        state_next = state;
        key_next   = key_q;
        idx_next   = idx_q;
        rk_we      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_next = LOAD;
                    key_next   = bus.key_in;
                    idx_next   = 4'd0;
                end
            end
            LOAD: begin
                rk_we      = 1'b1;
                state_next = EXPAND;
                key_next   = {n0, n1, n2, n3};
                idx_next   = idx_q + 4'd1;
            end
            EXPAND: begin
                rk_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_next = FIN;
                end else begin
                    key_next = {n0, n1, n2, n3};
                    idx_next = idx_q + 4'd1;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
`ifdef KEY_EXPANSION_ZEROIZE_EN
                key_next   = '0;
`else
                key_next   = key_q;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.rk_we   = rk_we;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rk_idx  = idx_q;
    assign bus.rk_data = key_q;
endmodule

// File: tb/tb_key_expansion_unit.sv
// Self-checking bench for key_expansion_unit: FIPS-197 style key expansion model
// plus an algorithmic S-box standing in for the shared external S-box bank.
module tb_key_expansion_unit;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    key_expansion_unit_if ifc ();

    key_expansion_unit #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] b;
        logic [7:0] s;
        for (int i = 1; i < 256; i++)
            if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
        b = inv;
        s = inv;
        for (int k = 0; k < 4; k++) begin
            b = {b[6:0], b[7]};
            s = s ^ b;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_fn(w[31:24]), sbox_fn(w[23:16]), sbox_fn(w[15:8]), sbox_fn(w[7:0])};
    endfunction

    function automatic logic [127:0] model_round_key(input logic [127:0] key, input int r);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (int i = 4; i < 4 * r + 4; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ temp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    always_comb ifc.sbox_out = sub_word(ifc.sbox_in);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_cnt = 0 in idle, else the n-th cycle after the accepted start.
    int           m_cnt  = 0;
    logic [127:0] m_key  = '0;
    logic [127:0] m_held = '0;
    logic [127:0] cm_exp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  <= 0;
            m_held <= '0;
        end else if (m_cnt == 0) begin
            if (ifc.start) begin
                m_cnt <= 1;
                m_key <= ifc.key_in;
            end
        end else if (m_cnt == 12) begin
            m_cnt <= 0;
`ifdef KEY_EXPANSION_ZEROIZE_EN
            m_held <= '0;
`else
            m_held <= model_round_key(m_key, 10);
`endif
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (m_cnt >= 1 && m_cnt <= 11)
                cm_exp = model_round_key(m_key, m_cnt - 1);
            else if (m_cnt == 12)
                cm_exp = model_round_key(m_key, 10);
            else
                cm_exp = m_held;
            check("busy", 128'(ifc.busy), 128'(m_cnt != 0));
            check("rk_we", 128'(ifc.rk_we), 128'(m_cnt >= 1 && m_cnt <= 11));
            check("done", 128'(ifc.done), 128'(m_cnt == 12));
            check("rk_data", ifc.rk_data, cm_exp);
            check("sbox_in", 128'(ifc.sbox_in), 128'({cm_exp[23:0], cm_exp[31:24]}));
            if (m_cnt >= 1 && m_cnt <= 11)
                check("rk_idx", 128'(ifc.rk_idx), 128'(m_cnt - 1));
        end
    end

    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] exp1,
                                 input logic [127:0] exp10, input bit prestarted,
                                 input bit irritate, input bit chain,
                                 input logic [127:0] chain_key, input bit abort_at4);
        int we_cnt   = 0;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_cyc = 0;
        if (!prestarted) begin
            @(negedge clk);
            ifc.key_in = key;
            ifc.start  = 1'b1;
        end
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) ifc.start = 1'b0;
            if (irritate && c == 6) begin
                ifc.start  = 1'b1;
                ifc.key_in = ~key;
            end
            if (irritate && c == 7) begin
                ifc.start  = 1'b0;
                ifc.key_in = key;
            end
            if (chain && c == 12) begin
                ifc.start  = 1'b1;
                ifc.key_in = chain_key;
            end
            if (abort_at4 && c == 5) begin
                check("pre_abort_idx", 128'(ifc.rk_idx), 128'd4);
                #2 rst = 1'b0;
                #1;
                check("abort_rk_we", 128'(ifc.rk_we), 128'd0);
                check("abort_busy", 128'(ifc.busy), 128'd0);
                check("abort_done", 128'(ifc.done), 128'd0);
                check("abort_rk_data", ifc.rk_data, 128'd0);
                return;
            end
            we_cnt   += int'(ifc.rk_we);
            busy_cnt += int'(ifc.busy);
            done_cnt += int'(ifc.done);
            if (ifc.done) done_cyc = c;
            if (c == 1)  check("lit_rk0", ifc.rk_data, key);
            if (c == 2)  check("lit_rk1", ifc.rk_data, exp1);
            if (c == 11) check("lit_rk10", ifc.rk_data, exp10);
`ifdef KEY_EXPANSION_ZEROIZE_EN
            if (c == 13) check("idle_rk_data", ifc.rk_data, 128'd0);
`else
            if (c == 13) check("idle_rk_data", ifc.rk_data, exp10);
`endif
        end
        check("we_count", 128'(we_cnt), 128'd11);
        check("busy_count", 128'(busy_cnt), 128'd12);
        check("done_count", 128'(done_cnt), 128'd1);
        check("done_cycle", 128'(done_cyc), 128'd12);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst        = 1'b0;
        ifc.start  = 1'b0;
        ifc.key_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 128'(ifc.busy), 128'd0);
        check("reset_rk_we", 128'(ifc.rk_we), 128'd0);
        check("reset_done", 128'(ifc.done), 128'd0);
        check("reset_rk_data", ifc.rk_data, 128'd0);
        check("reset_rk_idx", 128'(ifc.rk_idx), 128'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);

        // Zero key chained straight into a FIPS run that sees a stray start at idx 5.
        applyStimulus('0, ZERO_RK1, ZERO_RK10, 1'b0, 1'b0, 1'b1, FIPS_KEY, 1'b0);
        applyStimulus(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        repeat (2) @(negedge clk);

        applyStimulus('0, ZERO_RK1, ZERO_RK10, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_busy", 128'(ifc.busy), 128'd0);
        check("post_reset_rk_data", ifc.rk_data, 128'd0);

        applyStimulus(FIPS_KEY, FIPS_RK1, FIPS_RK10, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput();
    end

    task automatic checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask
endmodule
